// File: rtl/dlx_tb_pkg.sv
// rtl/dlx_tb_pkg.sv - shared state encoding and default widths for the DLX writeback checker
package dlx_tb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/dlx_wb_fifo.sv
// rtl/dlx_wb_fifo.sv - synchronous FIFO of expected writebacks with combinational head
module dlx_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dlx_wb_checker.sv
// rtl/dlx_wb_checker.sv - DLX bench controller: core reset pulse, in-order writeback compare, run status
// Optional per-entry data mask enabled by DLX_WB_CHECK_MASK_EN.
module dlx_wb_checker
  import dlx_tb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 16,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
`ifdef DLX_WB_CHECK_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  output logic              core_reset,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_add,
  input  logic [DATA_W-1:0] reg_data,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [31:0]       cycle_count
);

`ifdef DLX_WB_CHECK_MASK_EN
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif
  localparam int RC_W = $clog2(RST_CYC + 1);

  state_t             state;
  logic [RC_W-1:0]    rst_cnt;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic               q_full;
  logic               q_empty;
  logic               push;
  logic               pop;
  logic               checked_wb;
  logic               wb_err;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [DATA_W-1:0]  head_mask;

`ifdef DLX_WB_CHECK_MASK_EN
  assign push_entry = {exp_mask, exp_addr, exp_data};
  assign head_mask  = head[ADDR_W+DATA_W +: DATA_W];
`else
  assign push_entry = {exp_addr, exp_data};
  assign head_mask  = '1;
`endif
  assign head_addr = head[DATA_W +: ADDR_W];
  assign head_data = head[DATA_W-1:0];

  // R0 writes are architecturally dead, so they neither consume nor flag anything.
  assign checked_wb = (state == ST_RUN) & reg_write_en & (reg_add != '0);
  assign pop        = checked_wb & ~q_empty;
  assign wb_err     = checked_wb & (q_empty | (reg_add != head_addr) |
                                    ((reg_data & head_mask) != (head_data & head_mask)));
  assign exp_ready  = reset & (~q_full | pop);
  assign push       = exp_valid & exp_ready;

  dlx_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      rst_cnt        <= '0;
      core_reset     <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      cycle_count    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          core_reset <= 1'b1;
          if (start) begin
            state          <= ST_CORE_RST;
            rst_cnt        <= '0;
            core_reset     <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            cycle_count    <= '0;
          end
        end
        ST_CORE_RST: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            state      <= ST_RUN;
            core_reset <= 1'b1;
          end else begin
            rst_cnt    <= rst_cnt + 1'b1;
            core_reset <= 1'b0;
          end
        end
        ST_RUN: begin
          core_reset <= 1'b1;
          if (wb_err) begin
            if (err_count == 8'd0) begin
              first_err_addr <= reg_add;
              first_err_data <= reg_data;
            end
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
          // cycle_count is left at TIMEOUT-1 when the run is cut short.
          if (cycle_count == 32'(TIMEOUT - 1)) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            cycle_count <= cycle_count + 32'd1;
            if (q_empty && !reg_write_en) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (err_count == 8'd0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_wb_checker.sv
// tb/tb_dlx_wb_checker.sv - directed scoreboard bench for dlx_wb_checker
module tb_dlx_wb_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
`ifdef DLX_WB_CHECK_MASK_EN
  logic [31:0] exp_mask = '1;
`endif
  logic        core_reset;
  logic        reg_write_en = 1'b0;
  logic [4:0]  reg_add = '0;
  logic [31:0] reg_data = '0;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [7:0]  err_count;
  logic [4:0]  first_err_addr;
  logic [31:0] first_err_data;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [36:0] model_q[$];
  int          model_err;
  logic [4:0]  model_fa;
  logic [31:0] model_fd;

  dlx_wb_checker dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
`ifdef DLX_WB_CHECK_MASK_EN
    .exp_mask       (exp_mask),
`endif
    .core_reset     (core_reset),
    .reg_write_en   (reg_write_en),
    .reg_add        (reg_add),
    .reg_data       (reg_data),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .cycle_count    (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
    #1 check("push_ready", exp_ready, (model_q.size() < 16));
    if (exp_ready === 1'b1) model_q.push_back({a, d});
    @(negedge clock);
    exp_valid = 1'b0;
  endtask

  // Model of one RUN-cycle writeback; the DUT result is visible at the next negedge.
  task automatic model_wb(input logic [4:0] a, input logic [31:0] d);
    logic [36:0] h;
    logic        bad;
    if (a == 5'd0) return;
    bad = 1'b1;
    if (model_q.size() > 0) begin
      h = model_q.pop_front();
      bad = (h[36:32] != a) || (h[31:0] != d);
    end
    if (bad) begin
      if (model_err == 0) begin model_fa = a; model_fd = d; end
      model_err++;
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    reg_write_en = 1'b1; reg_add = a; reg_data = d;
    model_wb(a, d);
    @(negedge clock);
    reg_write_en = 1'b0;
  endtask

  task automatic start_run();
    int low;
    model_err = 0; model_fa = '0; model_fd = '0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("done_cleared", done, 1'b0);
    low = 0;
    while (core_reset === 1'b0 && low < 20) begin
      low++;
      @(negedge clock);
    end
    check("core_reset_low_cycles", low, 4);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      n++;
      @(negedge clock);
    end
    check("done", done, 1'b1);
  endtask

  task automatic check_result(input logic exp_timeout);
    check("pass", pass, (model_err == 0) && !exp_timeout);
    check("timeout", timeout, exp_timeout);
    check("err_count", err_count, model_err);
    check("first_err_addr", first_err_addr, model_fa);
    check("first_err_data", first_err_data, model_fd);
  endtask

  initial begin
    model_err = 0; model_fa = '0; model_fd = '0;
    #1 check("rst_core_reset", core_reset, 1'b0);
    check("rst_exp_ready", exp_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_core_reset", core_reset, 1'b1);
    check("idle_exp_ready", exp_ready, 1'b1);
    check("idle_done", done, 1'b0);
    check("idle_err", err_count, 8'd0);
    check("idle_cycles", cycle_count, 32'd0);

    // 1: two matching writebacks
    push_exp(5'd2, 32'd30);
    push_exp(5'd3, 32'd45);
    start_run();
    wb(5'd2, 32'd30);
    wb(5'd3, 32'd45);
    wait_done(20);
    check_result(1'b0);

    // 2: data mismatch
    push_exp(5'd2, 32'd30);
    start_run();
    wb(5'd2, 32'd31);
    wait_done(20);
    check_result(1'b0);

    // 3: unexpected write with empty queue, then an ignored R0 write
    start_run();
    wb(5'd5, 32'd7);
    wb(5'd0, 32'd99);
    wait_done(20);
    check_result(1'b0);

    // 4: fill queue, then push and pop in the same RUN cycle
    for (int i = 0; i < 16; i++) push_exp(5'(i + 1), 32'(100 + 3 * i));
    #1 check("full_not_ready", exp_ready, 1'b0);
    start_run();
    reg_write_en = 1'b1; reg_add = 5'd1; reg_data = 32'd100;
    exp_valid = 1'b1; exp_addr = 5'd17; exp_data = 32'd500;
    #1 check("full_ready_on_pop", exp_ready, 1'b1);
    model_wb(5'd1, 32'd100);
    model_q.push_back({5'd17, 32'd500});
    @(negedge clock);
    reg_write_en = 1'b0; exp_valid = 1'b0;
    #1 check("still_full", exp_ready, 1'b0);
    while (model_q.size() > 0) wb(model_q[0][36:32], model_q[0][31:0]);
    wait_done(20);
    check_result(1'b0);

    // 5: timeout with an entry never written back
    push_exp(5'd4, 32'd1);
    start_run();
    wait_done(1100);
    check_result(1'b1);
    check("timeout_cycles", cycle_count, 32'd1023);

    // 6: reset mid-run flushes everything
    reset = 1'b0;
    model_q.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_exp(5'd6, 32'd6);
    push_exp(5'd7, 32'd7);
    start_run();
    wb(5'd9, 32'd9);
    check("pre_abort_err", err_count, 8'd1);
    reset = 1'b0;
    model_q.delete();
    #1 check("abort_core_reset", core_reset, 1'b0);
    check("abort_err", err_count, 8'd0);
    check("abort_done", done, 1'b0);
    check("abort_cycles", cycle_count, 32'd0);
    check("abort_first_addr", first_err_addr, 5'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_run();
    wait_done(5);
    check_result(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
